// File: rtl/store_commit_queue_pkg.sv
// Shared types for the store commit queue.
//   ST_SB/ST_SH/ST_SW : store mode encodings presented by commit
//   sq_state_e        : drain FSM state
//   sq_entry_t        : formatted FIFO entry (word address, byte strobes, replicated data)
package store_commit_queue_pkg;

    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } sq_state_e;

    typedef struct packed {
        logic [29:0] addr_w;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sq_entry_t;

endpackage

// File: rtl/store_formatter.sv
// Combinational store formatter: turns a committed store into memory write form.
//   mode    : store mode (SB/SH/SW)
//   addr_lo : byte offset within the word (addr[1:0])
//   data    : LSB-aligned store data
//   legal   : mode is known and the address is naturally aligned for it
//   wstrb   : byte enables for the word
//   wdata   : store data replicated across every lane the size allows
module store_formatter
    import store_commit_queue_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic        legal,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        legal = 1'b0;
        wstrb = 4'b0000;
        wdata = 32'h0;
        case (mode)
            ST_SB: begin
                legal = 1'b1;
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            ST_SH: begin
                legal = ~addr_lo[0];
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{data[15:0]}};
            end
            ST_SW: begin
                legal = (addr_lo == 2'b00);
                wstrb = 4'b1111;
                wdata = data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_commit_queue.sv
// In-order store commit queue between commit and the data-memory write port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : commit-side handshake; in_mode/in_addr/in_data carry the store
//   mode_err          : one-cycle pulse after an illegal/misaligned store was consumed and dropped
//   mem_req/mem_ack   : memory write handshake; mem_addr/mem_wdata/mem_wstrb hold the head entry
//   ld_check_addr     : load address; ld_conflict flags a pending store to the same word
//   count/empty       : occupancy
module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int unsigned SQ_DEPTH     = 4,
    parameter int unsigned SQ_DEPTH_LOG = $clog2(SQ_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [2:0]            in_mode,
    input  logic [31:0]           in_addr,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  mode_err,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [31:0]           ld_check_addr,
    output logic                  ld_conflict,
    output logic [SQ_DEPTH_LOG:0] count,
    output logic                  empty
);

    localparam int unsigned CntW = SQ_DEPTH_LOG + 1;

    sq_entry_t                 entries_q [SQ_DEPTH];
    logic [SQ_DEPTH_LOG-1:0]   head_q, head_d;
    logic [SQ_DEPTH_LOG-1:0]   tail_q, tail_d;
    logic [CntW-1:0]           count_q, count_d;
    sq_state_e                 state_q, state_d;
    logic                      mode_err_q;

    logic        fmt_legal;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata;
    logic        accept;
    logic        push;
    logic        pop;
    sq_entry_t   head_entry;

    // Word compare ignores the byte offset of the load.
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_check_addr[1:0];

    store_formatter u_fmt (
        .mode    (in_mode),
        .addr_lo (in_addr[1:0]),
        .data    (in_data),
        .legal   (fmt_legal),
        .wstrb   (fmt_wstrb),
        .wdata   (fmt_wdata)
    );

    // Ready depends only on registered occupancy: no slot is offered through a same-cycle pop.
    assign in_ready = (count_q != CntW'(SQ_DEPTH));
    assign accept   = in_valid & in_ready;
    assign push     = accept & fmt_legal;
    assign pop      = (state_q == S_BUSY) & mem_ack;

    assign count_d = count_q + CntW'(push) - CntW'(pop);
    assign head_d  = pop  ? head_q + SQ_DEPTH_LOG'(1) : head_q;
    assign tail_d  = push ? tail_q + SQ_DEPTH_LOG'(1) : tail_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_BUSY;
            S_BUSY: if (pop && count_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            mode_err_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            mode_err_q <= accept & ~fmt_legal;
        end
    end

    // Payload storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q] <= '{addr_w: in_addr[31:2], wstrb: fmt_wstrb, wdata: fmt_wdata};
        end
    end

    assign head_entry = entries_q[head_q];
    assign mem_req    = (state_q == S_BUSY);
    assign mem_addr   = mem_req ? {head_entry.addr_w, 2'b00} : 32'h0;
    assign mem_wdata  = mem_req ? head_entry.wdata : 32'h0;
    assign mem_wstrb  = mem_req ? head_entry.wstrb : 4'b0000;

    // An entry is live when its distance from head is below the count.
    always_comb begin
        logic [SQ_DEPTH_LOG-1:0] offset;
        offset      = '0;
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            offset = SQ_DEPTH_LOG'(i) - head_q;
            if ({1'b0, offset} < count_q && entries_q[i].addr_w == ld_check_addr[31:2]) begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign mode_err = mode_err_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: tb/tb_store_commit_queue.sv
module tb_store_commit_queue;
    import store_commit_queue_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_mode;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mode_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] ld_check_addr;
    logic        ld_conflict;
    logic [2:0]  count;
    logic        empty;

    int errors = 0;
    int checks = 0;

    store_commit_queue #(.SQ_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_mode       (in_mode),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mode_err      (mode_err),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ack       (mem_ack),
        .ld_check_addr (ld_check_addr),
        .ld_conflict   (ld_conflict),
        .count         (count),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] d);
        in_valid = v;
        in_mode  = m;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        mem_ack       = 1'b0;
        ld_check_addr = 32'h0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mode_err", 32'(mode_err), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // SB at offset 3 with mem_ack already high (ignored while idle)
        drive(1'b1, ST_SB, 32'h0000_1003, 32'h0000_00AB);
        mem_ack = 1'b1;
        step();
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        check("sb_count1", 32'(count), 32'd1);
        check("sb_no_req_yet", 32'(mem_req), 32'd0);
        step();
        check("sb_req", 32'(mem_req), 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_wstrb", 32'(mem_wstrb), 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        step();
        check("sb_empty", 32'(empty), 32'd1);
        check("sb_req_drop", 32'(mem_req), 32'd0);
        check("sb_addr_zero", mem_addr, 32'h0);
        mem_ack = 1'b0;

        // Fill with four SW stores
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ST_SW, 32'h100 + 32'(4 * i), {4{8'(8'h11 * (i + 1))}});
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, ST_SW, 32'h110, 32'h5555_5555);
        step();
        check("fifth_not_taken", 32'(count), 32'd4);
        check("full_head_addr", mem_addr, 32'h100);
        check("full_head_data", mem_wdata, 32'h1111_1111);
        check("full_head_strb", 32'(mem_wstrb), 32'hF);

        // Ack while full with in_valid still high: pop only
        mem_ack = 1'b1;
        step();
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_ready", 32'(in_ready), 32'd1);
        check("drain_addr1", mem_addr, 32'h104);
        drive(1'b0, ST_SW, 32'h0, 32'h0);
        step();
        check("drain_count2", 32'(count), 32'd2);
        check("drain_addr2", mem_addr, 32'h108);
        check("drain_data2", mem_wdata, 32'h3333_3333);
        step();
        check("drain_count1", 32'(count), 32'd1);
        check("drain_addr3", mem_addr, 32'h10C);
        check("drain_data3", mem_wdata, 32'h4444_4444);
        step();
        check("drain_count0", 32'(count), 32'd0);
        check("drain_req_off", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // Illegal stores are consumed and dropped
        drive(1'b1, ST_SH, 32'h201, 32'h1234);
        step();
        check("sh_mis_err", 32'(mode_err), 32'd1);
        check("sh_mis_count", 32'(count), 32'd0);
        drive(1'b1, ST_SW, 32'h302, 32'h1234);
        step();
        check("sw_mis_err", 32'(mode_err), 32'd1);
        check("sw_mis_count", 32'(count), 32'd0);
        drive(1'b1, 3'b011, 32'h300, 32'h1234);
        step();
        check("bad_mode_err", 32'(mode_err), 32'd1);
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        step();
        check("err_pulse_end", 32'(mode_err), 32'd0);
        check("err_no_req", 32'(mem_req), 32'd0);
        check("err_count", 32'(count), 32'd0);

        // Load conflict against a pending SW at 0x400
        drive(1'b1, ST_SW, 32'h400, 32'hDEAD_BEEF);
        ld_check_addr = 32'h403;
        #1;
        check("ld_not_yet", 32'(ld_conflict), 32'd0);
        step();
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        check("ld_hit", 32'(ld_conflict), 32'd1);
        ld_check_addr = 32'h404;
        #1;
        check("ld_miss_next_word", 32'(ld_conflict), 32'd0);
        ld_check_addr = 32'h403;
        step();
        check("ld_req", 32'(mem_req), 32'd1);
        check("ld_hit_inflight", 32'(ld_conflict), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check("ld_retired", 32'(ld_conflict), 32'd0);
        check("ld_empty", 32'(empty), 32'd1);

        // SH formatting, simultaneous push/pop, then async reset mid-handshake
        drive(1'b1, ST_SH, 32'h602, 32'hCAFE_1234);
        step();
        drive(1'b1, ST_SW, 32'h504, 32'h0BAD_F00D);
        step();
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        check("sh_req", 32'(mem_req), 32'd1);
        check("sh_addr", mem_addr, 32'h600);
        check("sh_wstrb", 32'(mem_wstrb), 32'hC);
        check("sh_wdata", mem_wdata, 32'h1234_1234);
        check("two_count", 32'(count), 32'd2);
        drive(1'b1, ST_SB, 32'h506, 32'h5A);
        mem_ack = 1'b1;
        step();
        drive(1'b0, ST_SB, 32'h0, 32'h0);
        mem_ack = 1'b0;
        check("pushpop_count", 32'(count), 32'd2);
        check("pushpop_head", mem_addr, 32'h504);
        check("pushpop_data", mem_wdata, 32'h0BAD_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", 32'(mem_req), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_req", 32'(mem_req), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_commit_queue.md
Name: store_commit_queue

Overview:
- Sits between the commit stage and the data-memory write port.
- Accepts at most one committed store per cycle (mode, address, data) into an in-order FIFO, then drains the FIFO to memory over a req/ack handshake.
- Generates byte strobes and lane-replicated write data from the store mode.
- Gives the load unit a word-address conflict check against all stores still pending.

Parameters:
SQ_DEPTH, 4, FIFO entries; power of two, >= 2
SQ_DEPTH_LOG, $clog2(SQ_DEPTH), pointer width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  commit presents a store this cycle
in_mode  input  3  store mode: 000 SB, 001 SH, 010 SW
in_addr  input  32  byte address
in_data  input  32  store data, LSB-aligned
in_ready  output  1  queue can accept; commit must hold its second store while low
mode_err  output  1  one-cycle pulse: accepted store was illegal/misaligned and dropped
mem_req  output  1  write request to data memory
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  output  32  lane-replicated write data
mem_wstrb  output  4  byte enables
mem_ack  input  1  memory accepted current request this cycle
ld_check_addr  input  32  load address to check
ld_conflict  output  1  some pending entry has the same addr[31:2]
count  output  SQ_DEPTH_LOG+1  number of valid entries
empty  output  1  count==0

Behaviour:
- Reset is asynchronous active-low (clk, rst_n). While rst_n is low, all of the following are 0 and take effect immediately, including mid-handshake: head/tail pointers, count, state, mem_req, mode_err. in_ready is then 1 and empty is 1.
- Handshake: enqueue when in_valid && in_ready. in_ready = (count != SQ_DEPTH) and is registered-state based.
  - No pass-through when full: in_ready stays 0 even if a pop happens in the same cycle.
- Legality check at enqueue:
  - Illegal: SH with addr[0]=1; SW with addr[1:0]!=0; any mode other than 000/001/010.
  - An illegal store is consumed (handshake completes), not written to the FIFO, and mode_err=1 on the next cycle for one cycle.
- Entry format:
  - Stored fields: {addr[31:2], wstrb, wdata}, formatted at enqueue.
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{d[7:0]}}.
  - SH: wstrb = 4'b0011 << addr[1:0]; wdata = {2{d[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = d.
- Drain FSM (registered state):
  - S_IDLE: mem_req=0. Go to S_BUSY when count != 0 at the clock edge. An enqueue into an empty queue therefore gives mem_req=1 one cycle after the enqueue edge.
  - S_BUSY: mem_req=1. mem_addr/mem_wdata/mem_wstrb reflect the head entry and stay stable until mem_ack.
    - On mem_ack: pop head.
    - If count after the pop (including a same-cycle push) is 0, go to S_IDLE; otherwise stay in S_BUSY, so back-to-back acks retire one entry per cycle.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo SQ_DEPTH (wrap-around is natural overflow of SQ_DEPTH_LOG bits).
- mem_ack while in S_IDLE is ignored.
- mem_addr/mem_wdata/mem_wstrb are 0 while mem_req=0.
- ld_conflict is combinational over the registered valid entries only, including the in-flight head. A store enqueued this cycle is not visible until the next cycle. Compare on bits [31:2] only.
- Ordering: strictly FIFO; no merging or coalescing.

Decomposition:
- Shared package: store mode constants (ST_SB/ST_SH/ST_SW), FSM state enum (S_IDLE, S_BUSY), and the sq_entry struct {addr_w[29:0], wstrb[3:0], wdata[31:0]}.
- One sub-module: store_formatter. It is combinational and maps mode/addr/data to {legal, wstrb, wdata}.
- The queue module holds the FIFO, FSM and conflict compare.

Test Plan:
- Reset, then SB addr=0x1003 data=0x000000AB; mem_ack high -> 2 cycles later mem_req=1, mem_addr=0x1000, mem_wstrb=1000, mem_wdata=0xABABABAB; empty=1 the cycle after the ack.
- Enqueue 4 SW (0x100,0x104,0x108,0x10C) with mem_ack=0 -> count=4, in_ready=0; 5th in_valid not accepted. Then hold mem_ack=1 -> four consecutive acks retire in order, with count 4,3,2,1,0.
- Full queue, in_valid=1 with mem_ack in same cycle -> pop occurs, no push; in_ready=1 the next cycle.
- SH addr=0x201, then SW addr=0x302 -> both consumed, mode_err pulses each time, count stays 0, mem_req never rises.
- Pending SW at 0x400: ld_check_addr=0x403 -> ld_conflict=1; ld_check_addr=0x404 -> 0; after the ack retires it -> ld_conflict=0 for 0x403.
- rst_n low while mem_req=1 with 2 entries -> mem_req and count drop to 0 asynchronously; after release, in_ready=1 and no request issues.
